fc_argmax_layer: RTL and testbench

- Parametrised fully-connected output layer with argmax; successor to the fixed 16-lane / 10-class classifier stage.
- Multiply-accumulates N_CLASSES dot products over N_CHUNKS × N_LANES features, adds a per-class bias, and applies optional ReLU.
- Returns the winning class index and its score through a ready/valid result port.
- Weight, bias and feature storage sit outside the block, so one RTL serves any layer size.

---
 rtl/fc_argmax_layer.sv | 232 +++++++++++++++++++++++
 tb/tb_fc_argmax_layer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_argmax_layer.sv
`default_nettype none
// ============================================================================
// Module   : fc_argmax_layer
// Brief    : Fully-connected output layer with bias, optional ReLU and argmax.
//            Streams weight/feature chunks from external storage, accumulates
//            one dot product per class and reports the winning class/score
//            through a ready/valid result port.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module fc_argmax_layer #(
    parameter int N_LANES   = 16,
    parameter int N_CHUNKS  = 4,
    parameter int N_CLASSES = 10,
    parameter int DIN_W     = 18,
    parameter int W_W       = 9,
    parameter int B_W       = 9,
    parameter int ACC_W     = 36,
    parameter int RELU_EN   = 1,
    parameter int IDX_W     = 8
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       strt,
    input  logic                                       clear,
    output logic [$clog2(N_CLASSES*N_CHUNKS)-1:0]      rd_addr,
    output logic [((N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1)-1:0] din_chunk,
    input  logic [N_LANES*W_W-1:0]                     w_data,
    input  logic [N_LANES*DIN_W-1:0]                   din,
    output logic [$clog2(N_CLASSES)-1:0]               b_addr,
    input  logic [B_W-1:0]                             b_data,
    output logic                                       busy,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [IDX_W-1:0]                           out_class,
    output logic [ACC_W-1:0]                           out_score
);

    localparam int c_TOTAL = N_CLASSES * N_CHUNKS;
    localparam int c_AW    = $clog2(c_TOTAL);
    localparam int c_CW    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int c_KW    = $clog2(N_CLASSES);
    // Full-precision width of one chunk's lane sum; the adder tree works at
    // the wider of this and ACC_W so truncation happens only once at the end.
    localparam int c_PW    = DIN_W + W_W + $clog2(N_LANES) + 1;
    localparam int c_SW    = (c_PW > ACC_W) ? c_PW : ACC_W;
    localparam logic signed [ACC_W-1:0] c_MAX_INIT =
        (RELU_EN != 0) ? '0 : {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;

    // Stage 1: address issued last cycle, data arrives on the bus now
    logic                     r_p1_valid;
    logic [c_CW-1:0]          r_p1_chunk;
    logic [c_KW-1:0]          r_p1_class;
    logic signed [ACC_W-1:0]  r_acc;

    // Stage 2: completed class score waiting for the compare
    logic                     r_sc_valid;
    logic                     r_sc_last;
    logic [c_KW-1:0]          r_sc_class;
    logic signed [ACC_W-1:0]  r_sc_score;

    // Running maximum
    logic signed [ACC_W-1:0]  r_max;
    logic [c_KW-1:0]          r_max_cls;

    logic                     w_accept;
    logic signed [c_SW-1:0]   w_prod [N_LANES];
    logic signed [c_SW-1:0]   w_dot_full;
    logic signed [ACC_W-1:0]  w_dot;
    logic signed [ACC_W-1:0]  w_bias;
    logic signed [ACC_W-1:0]  w_acc_in;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [ACC_W-1:0]  w_class_sum;
    logic signed [ACC_W-1:0]  w_relu;
    logic                     w_take;
    logic signed [ACC_W-1:0]  w_new_max;
    logic [c_KW-1:0]          w_new_cls;
    logic                     w_p1_last_chunk;

    assign w_accept = (r_state == S_IDLE) && strt && !out_valid;

    // Per-lane sign-extended products
    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        logic signed [c_SW-1:0] w_f;
        logic signed [c_SW-1:0] w_w;
        assign w_f = {{(c_SW-DIN_W){din[g*DIN_W+DIN_W-1]}}, din[g*DIN_W +: DIN_W]};
        assign w_w = {{(c_SW-W_W){w_data[g*W_W+W_W-1]}}, w_data[g*W_W +: W_W]};
        assign w_prod[g] = w_f * w_w;
    end

    // Lane sum, accumulate, bias, ReLU and the signed strict compare
    always_comb begin
        w_dot_full = '0;
        for (int i = 0; i < N_LANES; i++) begin
            w_dot_full = w_dot_full + w_prod[i];
        end
        w_dot           = w_dot_full[ACC_W-1:0];
        w_bias          = {{(ACC_W-B_W){b_data[B_W-1]}}, b_data};
        w_acc_in        = (r_p1_chunk == '0) ? '0 : r_acc;
        w_acc_next      = w_acc_in + w_dot;
        w_class_sum     = w_acc_next + w_bias;
        w_p1_last_chunk = (r_p1_chunk == c_CW'(N_CHUNKS-1));
        w_relu          = ((RELU_EN != 0) && r_sc_score[ACC_W-1]) ? '0 : r_sc_score;
        w_take          = (w_relu > r_max);
        w_new_max       = w_take ? w_relu : r_max;
        w_new_cls       = w_take ? r_sc_class : r_max_cls;
    end

    // Control FSM: address generation, busy and result handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            rd_addr   <= '0;
            din_chunk <= '0;
            b_addr    <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            r_state   <= S_IDLE;
            rd_addr   <= '0;
            din_chunk <= '0;
            b_addr    <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_RUN;
                        rd_addr   <= '0;
                        din_chunk <= '0;
                        b_addr    <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (rd_addr == c_AW'(c_TOTAL-1)) begin
                        r_state <= S_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + c_AW'(1);
                        if (din_chunk == c_CW'(N_CHUNKS-1)) begin
                            din_chunk <= '0;
                            b_addr    <= b_addr + c_KW'(1);
                        end else begin
                            din_chunk <= din_chunk + c_CW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_sc_valid && r_sc_last) begin
                        r_state   <= S_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath pipeline: accumulate chunks, hand class scores to the compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_valid <= 1'b0;
            r_p1_chunk <= '0;
            r_p1_class <= '0;
            r_acc      <= '0;
            r_sc_valid <= 1'b0;
            r_sc_last  <= 1'b0;
            r_sc_class <= '0;
            r_sc_score <= '0;
            r_max      <= c_MAX_INIT;
            r_max_cls  <= '0;
            out_class  <= '0;
            out_score  <= '0;
        end else if (clear) begin
            r_p1_valid <= 1'b0;
            r_p1_chunk <= '0;
            r_p1_class <= '0;
            r_acc      <= '0;
            r_sc_valid <= 1'b0;
            r_sc_last  <= 1'b0;
            r_sc_class <= '0;
            r_sc_score <= '0;
            r_max      <= c_MAX_INIT;
            r_max_cls  <= '0;
        end else begin
            r_p1_valid <= (r_state == S_RUN);
            r_p1_chunk <= din_chunk;
            r_p1_class <= b_addr;
            r_sc_valid <= 1'b0;
            if (r_p1_valid) begin
                if (w_p1_last_chunk) begin
                    // b_data addressed with this class's last chunk is on the bus now
                    r_sc_score <= w_class_sum;
                    r_sc_class <= r_p1_class;
                    r_sc_last  <= (r_p1_class == c_KW'(N_CLASSES-1));
                    r_sc_valid <= 1'b1;
                end else begin
                    r_acc <= w_acc_next;
                end
            end
            if (w_accept) begin
                r_max     <= c_MAX_INIT;
                r_max_cls <= '0;
            end else if (r_sc_valid) begin
                r_max     <= w_new_max;
                r_max_cls <= w_new_cls;
                if (r_sc_last) begin
                    out_score <= w_new_max;
                    out_class <= IDX_W'(w_new_cls);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fc_argmax_layer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_argmax_layer
// Brief    : Directed self-checking bench for fc_argmax_layer: default layer
//            with and without ReLU, plus a small max-magnitude configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_argmax_layer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic strt = 1'b0;
    logic clear = 1'b0;
    logic out_ready = 1'b0;
    logic strt_s = 1'b0;
    logic out_ready_s = 1'b0;

    always #5 clk = ~clk;

    // Default-size instances (ReLU on / ReLU off) share stimulus
    logic [5:0]   rd_addr0, rd_addr1;
    logic [1:0]   din_chunk0, din_chunk1;
    logic [3:0]   b_addr0, b_addr1;
    logic [143:0] w_data0, w_data1;
    logic [287:0] din0, din1;
    logic [8:0]   b_data0, b_data1;
    logic         busy0, busy1, out_valid0, out_valid1;
    logic [7:0]   out_class0, out_class1;
    logic [35:0]  out_score0, out_score1;

    // Small instance
    logic [2:0]   rd_addr_s;
    logic [0:0]   din_chunk_s;
    logic [1:0]   b_addr_s;
    logic [35:0]  w_data_s;
    logic [71:0]  din_s;
    logic [8:0]   b_data_s;
    logic         busy_s, out_valid_s;
    logic [7:0]   out_class_s;
    logic [35:0]  out_score_s;

    logic [143:0] wmem [64];
    logic [287:0] fmem [4];
    logic [8:0]   bmem [16];
    logic [35:0]  wmem_s [8];
    logic [71:0]  fmem_s [2];
    logic [8:0]   bmem_s [4];

    int n_err = 0;
    int n_chk = 0;
    int lat;

    fc_argmax_layer dut0 (
        .clk(clk), .rst_n(rst_n), .strt(strt), .clear(clear),
        .rd_addr(rd_addr0), .din_chunk(din_chunk0), .w_data(w_data0), .din(din0),
        .b_addr(b_addr0), .b_data(b_data0), .busy(busy0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_class(out_class0), .out_score(out_score0)
    );

    fc_argmax_layer #(.RELU_EN(0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .strt(strt), .clear(clear),
        .rd_addr(rd_addr1), .din_chunk(din_chunk1), .w_data(w_data1), .din(din1),
        .b_addr(b_addr1), .b_data(b_data1), .busy(busy1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_class(out_class1), .out_score(out_score1)
    );

    fc_argmax_layer #(.N_LANES(4), .N_CHUNKS(2), .N_CLASSES(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .strt(strt_s), .clear(clear),
        .rd_addr(rd_addr_s), .din_chunk(din_chunk_s), .w_data(w_data_s), .din(din_s),
        .b_addr(b_addr_s), .b_data(b_data_s), .busy(busy_s), .out_valid(out_valid_s),
        .out_ready(out_ready_s), .out_class(out_class_s), .out_score(out_score_s)
    );

    // External storage with one cycle of read latency
    always @(posedge clk) begin
        w_data0  <= wmem[rd_addr0];
        din0     <= fmem[din_chunk0];
        b_data0  <= bmem[b_addr0];
        w_data1  <= wmem[rd_addr1];
        din1     <= fmem[din_chunk1];
        b_data1  <= bmem[b_addr1];
        w_data_s <= wmem_s[rd_addr_s];
        din_s    <= fmem_s[din_chunk_s];
        b_data_s <= bmem_s[b_addr_s];
    end

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 64; a++) wmem[a] = '0;
        for (int j = 0; j < 4; j++)  fmem[j] = '0;
        for (int c = 0; c < 16; c++) bmem[c] = '0;
    endtask

    task automatic set_feat(input int j, input int v);
        for (int l = 0; l < 16; l++) fmem[j][l*18 +: 18] = 18'(v);
    endtask

    task automatic set_w(input int cls, input int ch, input int lane, input int v);
        wmem[cls*4+ch][lane*9 +: 9] = 9'(v);
    endtask

    // Pulse strt, then count edges until out_valid (bounded)
    task automatic run(output int n);
        @(negedge clk); strt = 1'b1;
        @(posedge clk); #1; strt = 1'b0;
        chk("busy_on_accept", busy0, 1);
        n = 0;
        while (!out_valid0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic ack();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk("valid_drop_after_ack", out_valid0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        clear_mem();
        for (int a = 0; a < 8; a++) wmem_s[a] = '0;
        for (int j = 0; j < 2; j++) fmem_s[j] = '0;
        for (int c = 0; c < 4; c++) bmem_s[c] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_addr", rd_addr0, 0);
        chk("rst_din_chunk", din_chunk0, 0);
        chk("rst_b_addr", b_addr0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_class", out_class0, 0);
        chk("rst_out_score", out_score0, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Bias-only scores, tie between classes 3 and 4
        for (int j = 0; j < 4; j++) set_feat(j, 1);
        bmem[0] = 9'd0; bmem[1] = 9'd5; bmem[2] = 9'd3; bmem[3] = 9'd9; bmem[4] = 9'd9;
        bmem[5] = 9'd1; bmem[6] = 9'd0; bmem[7] = 9'd0; bmem[8] = 9'd2; bmem[9] = 9'd0;
        run(lat);
        chk("t1_latency", lat, 42);
        chk("t1_class", out_class0, 3);
        chk("t1_score", $signed(out_score0), 9);
        chk("t1_busy_low", busy0, 0);
        chk("t1_rd_addr_hold", rd_addr0, 39);
        ack();

        // Class 7 weights all +1, features all 1
        clear_mem();
        for (int j = 0; j < 4; j++) set_feat(j, 1);
        for (int ch = 0; ch < 4; ch++)
            for (int l = 0; l < 16; l++) set_w(7, ch, l, 1);
        run(lat);
        chk("t2_class", out_class0, 7);
        chk("t2_score", $signed(out_score0), 64);
        chk("t2_nr_class", out_class1, 7);
        chk("t2_nr_score", $signed(out_score1), 64);
        ack();

        // All scores negative: -100..-91 with class 6 at -50
        clear_mem();
        for (int c = 0; c < 10; c++) bmem[c] = 9'(c - 100);
        bmem[6] = 9'(-50);
        run(lat);
        chk("t3_nr_class", out_class1, 6);
        chk("t3_nr_score", $signed(out_score1), -50);
        chk("t3_relu_class", out_class0, 0);
        chk("t3_relu_score", $signed(out_score0), 0);
        ack();

        // Chunk-dependent features; class c uses lane 0 of chunk c%4
        clear_mem();
        for (int j = 0; j < 4; j++) set_feat(j, j + 1);
        for (int c = 0; c < 10; c++) set_w(c, c % 4, 0, c + 1);
        bmem[9] = 9'd13;
        run(lat);
        chk("t4_latency", lat, 42);
        chk("t4_class", out_class0, 9);
        chk("t4_score", $signed(out_score0), 33);
        chk("t4_nr_class", out_class1, 9);
        chk("t4_nr_score", $signed(out_score1), 33);

        // Back-pressure: result holds for 20 cycles, strt ignored
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); strt = (i % 4 == 0);
            @(posedge clk); #1; strt = 1'b0;
            chk("hold_valid", out_valid0, 1);
            chk("hold_class", out_class0, 9);
            chk("hold_score", $signed(out_score0), 33);
            chk("hold_busy", busy0, 0);
        end
        @(negedge clk); out_ready = 1'b1; strt = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0; strt = 1'b0;
        chk("ack_valid_low", out_valid0, 0);
        chk("ack_strt_ignored", busy0, 0);
        run(lat);
        chk("rerun_latency", lat, 42);
        chk("rerun_class", out_class0, 9);
        ack();

        // Clear at cycle 17 of a run
        @(negedge clk); strt = 1'b1;
        @(posedge clk); #1; strt = 1'b0;
        repeat (16) @(posedge clk);
        #1; clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
        chk("clear_busy", busy0, 0);
        chk("clear_valid", out_valid0, 0);
        chk("clear_rd_addr", rd_addr0, 0);
        chk("clear_class_kept", out_class0, 9);
        chk("clear_score_kept", $signed(out_score0), 33);
        repeat (3) @(posedge clk);
        chk("clear_stays_idle", busy0, 0);
        run(lat);
        chk("restart_latency", lat, 42);
        chk("restart_class", out_class0, 9);
        chk("restart_score", $signed(out_score0), 33);
        ack();

        // Reset mid-operation
        @(negedge clk); strt = 1'b1;
        @(posedge clk); #1; strt = 1'b0;
        repeat (10) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_class", out_class0, 0);
        chk("mid_rst_score", out_score0, 0);
        chk("mid_rst_rd_addr", rd_addr0, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Small configuration, max-magnitude operands on every lane
        for (int j = 0; j < 2; j++)
            for (int l = 0; l < 4; l++) fmem_s[j][l*18 +: 18] = 18'h20000;
        for (int a = 0; a < 6; a++)
            for (int l = 0; l < 4; l++) wmem_s[a][l*9 +: 9] = 9'h100;
        @(negedge clk); strt_s = 1'b1;
        @(posedge clk); #1; strt_s = 1'b0;
        lat = 0;
        while (!out_valid_s && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk("small_latency", lat, 8);
        chk("small_class", out_class_s, 0);
        chk("small_score", $signed(out_score_s), 268435456);
        @(negedge clk); out_ready_s = 1'b1;
        @(posedge clk); #1; out_ready_s = 1'b0;
        chk("small_ack", out_valid_s, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
